// File: rtl/ofdm_cp_remover_if.sv
// Avalon-ST sample bundle for the OFDM cyclic-prefix remover.
// master = symbol source / sink side, slave = remover side.
interface ofdm_cp_remover_if #(
  parameter int DATA_W = 34
);
  logic [DATA_W-1:0] asi_in0_data;
  logic              asi_in0_valid;
  logic              asi_in0_ready;
  logic              asi_in0_startofpacket;
  logic              asi_in0_endofpacket;
  logic [DATA_W-1:0] aso_out0_data;
  logic              aso_out0_valid;
  logic              aso_out0_ready;
  logic              aso_out0_startofpacket;
  logic              aso_out0_endofpacket;
  logic [1:0]        aso_out0_error;

  modport master (
    output asi_in0_data,
    output asi_in0_valid,
    input  asi_in0_ready,
    output asi_in0_startofpacket,
    output asi_in0_endofpacket,
    input  aso_out0_data,
    input  aso_out0_valid,
    output aso_out0_ready,
    input  aso_out0_startofpacket,
    input  aso_out0_endofpacket,
    input  aso_out0_error
  );

  modport slave (
    input  asi_in0_data,
    input  asi_in0_valid,
    output asi_in0_ready,
    input  asi_in0_startofpacket,
    input  asi_in0_endofpacket,
    output aso_out0_data,
    output aso_out0_valid,
    input  aso_out0_ready,
    output aso_out0_startofpacket,
    output aso_out0_endofpacket,
    output aso_out0_error
  );
endinterface

// File: rtl/ofdm_cp_remover.sv
// OFDM receive cyclic-prefix remover: strips CP_LEN prefix beats,
// forwards N_FFT body beats and flags truncated/overlong symbols.
module ofdm_cp_remover #(
  parameter int DATA_W = 34,
  parameter int N_FFT  = 64,
  parameter int CP_LEN = 16
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  ofdm_cp_remover_if.slave     st
);

  localparam int TOT = CP_LEN + N_FFT;
  localparam int IW  = $clog2(TOT);

  localparam logic [IW-1:0] CP_END = IW'(CP_LEN - 1);
  localparam logic [IW-1:0] FIRST  = IW'(CP_LEN);
  localparam logic [IW-1:0] LAST   = IW'(TOT - 1);

  typedef enum logic [1:0] {
    IDLE,
    DROP,
    PASS,
    DISCARD
  } state_t;

  state_t            state;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_sop;
  logic              out_eop;
  logic [1:0]        out_err;

  logic in_xfer;
  logic in_sop;
  logic in_eop;
  logic at_last;

  assign st.asi_in0_ready = !reset_reset &
    (state != PASS || !out_valid || st.aso_out0_ready);

  assign in_xfer = st.asi_in0_valid & st.asi_in0_ready;
  assign in_sop  = st.asi_in0_startofpacket;
  assign in_eop  = st.asi_in0_endofpacket;
  assign at_last = (idx == LAST);

  assign st.aso_out0_data          = out_data;
  assign st.aso_out0_valid         = out_valid;
  assign st.aso_out0_startofpacket = out_sop;
  assign st.aso_out0_endofpacket   = out_eop;
  assign st.aso_out0_error         = out_err;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state     <= IDLE;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_err   <= 2'b00;
    end else begin
      // Taken beat retires unless a new one replaces it below.
      if (st.aso_out0_ready) begin
        out_valid <= 1'b0;
        out_sop   <= 1'b0;
        out_eop   <= 1'b0;
        out_err   <= 2'b00;
      end
      if (in_xfer) begin
        unique case (state)
          IDLE: begin
            if (in_sop && !in_eop) begin
              idx   <= IW'(1);
              state <= (CP_LEN == 1) ? PASS : DROP;
            end
          end
          DROP: begin
            if (in_eop) begin
              idx   <= '0;
              state <= IDLE;
            end else begin
              idx <= idx + IW'(1);
              if (idx == CP_END) state <= PASS;
            end
          end
          PASS: begin
            out_valid <= 1'b1;
            out_data  <= st.asi_in0_data;
            out_sop   <= (idx == FIRST);
            out_eop   <= at_last | in_eop;
            out_err   <= {at_last & ~in_eop,
                          ~at_last & in_eop};
            if (at_last || in_eop) begin
              idx   <= '0;
              state <= (at_last && !in_eop) ? DISCARD : IDLE;
            end else begin
              idx <= idx + IW'(1);
            end
          end
          DISCARD: begin
            if (in_eop) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ofdm_cp_remover.sv
// Randomized self-checking bench for ofdm_cp_remover with a
// symbol-level reference model and a beat scoreboard.
module tb_ofdm_cp_remover;

  localparam int DW  = 34;
  localparam int NF  = 64;
  localparam int CP  = 16;
  localparam int TOT = CP + NF;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          s;
    logic          e;
    logic [1:0]    er;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ofdm_cp_remover_if #(.DATA_W(DW)) bus ();

  ofdm_cp_remover #(
    .DATA_W (DW),
    .N_FFT  (NF),
    .CP_LEN (CP)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .st          (bus.slave)
  );

  beat_t         expq[$];
  int            n_chk = 0;
  int            n_pass = 0;
  int            n_fail = 0;
  bit            bp = 1'b0;
  int            gap_pct = 0;
  bit            mid_sop = 1'b0;
  bit            lat_pending = 1'b0;
  logic [DW-1:0] lat_data;
  bit            prev_stall = 1'b0;
  beat_t         prev_beat;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic bad(input string tag);
    n_chk++;
    n_fail++;
    $error("FAIL %s: got event want none", tag);
  endtask

  // Symbol-level model: what one packet of len beats should yield.
  task automatic model(input int len, input logic [DW-1:0] d[$]);
    int    last;
    beat_t b;
    if (len <= CP) return;
    last = (len < TOT) ? len : TOT;
    for (int i = CP; i < last; i++) begin
      b.d  = d[i];
      b.s  = (i == CP);
      b.e  = (i == last - 1);
      b.er = 2'b00;
      if (b.e && len < TOT) b.er = 2'b01;
      if (b.e && len > TOT) b.er = 2'b10;
      expq.push_back(b);
    end
  endtask

  task automatic observe();
    beat_t cur;
    beat_t ex;
    cur = {bus.aso_out0_data, bus.aso_out0_startofpacket,
           bus.aso_out0_endofpacket, bus.aso_out0_error};
    if (prev_stall) chk("hold", 64'(cur), 64'(prev_beat));
    if (lat_pending) begin
      chk("latency",
          {28'd0, bus.aso_out0_valid,
           bus.aso_out0_startofpacket, bus.aso_out0_data},
          {28'd0, 2'b11, lat_data});
      lat_pending = 1'b0;
    end
    if (!rst)
      chk("in_ready",
          64'(bus.asi_in0_ready |
              (bus.aso_out0_valid & ~bus.aso_out0_ready)),
          64'd1);
    if (bus.aso_out0_valid && bus.aso_out0_ready) begin
      if (expq.size() == 0) begin
        bad("spurious_out");
      end else begin
        ex = expq.pop_front();
        chk("out_beat", 64'(cur), 64'(ex));
      end
    end
    prev_stall = !rst && bus.aso_out0_valid && !bus.aso_out0_ready;
    prev_beat  = cur;
  endtask

  task automatic tick(input bit v, input logic [DW-1:0] d,
                      input bit s, input bit e, output bit acc);
    @(negedge clk);
    bus.asi_in0_valid         = v;
    bus.asi_in0_data          = d;
    bus.asi_in0_startofpacket = s;
    bus.asi_in0_endofpacket   = e;
    bus.aso_out0_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    acc = v && bus.asi_in0_ready;
    observe();
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b0, acc);
  endtask

  task automatic send(input int len, input bit use_idx,
                      input bit lat);
    logic [DW-1:0] d[$];
    bit            acc;
    bit            s;
    int            guard;
    for (int i = 0; i < len; i++)
      d.push_back(use_idx ? DW'(i) : DW'({$urandom(), $urandom()}));
    model(len, d);
    for (int i = 0; i < len; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct)
        tick(1'b0, '0, 1'b0, 1'b0, acc);
      s = (i == 0) || (mid_sop && $urandom_range(0, 15) == 0);
      guard = 0;
      acc = 1'b0;
      while (!acc && guard < 1000) begin
        tick(1'b1, d[i], s, i == len - 1, acc);
        guard++;
      end
      if (!acc) bad("in_timeout");
      if (lat && i == CP) begin
        lat_pending = 1'b1;
        lat_data    = d[i];
      end
    end
  endtask

  task automatic junk(input int n);
    bit acc;
    for (int i = 0; i < n; i++)
      tick(1'b1, DW'($urandom()), 1'b0,
           1'($urandom_range(0, 1)), acc);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (expq.size() != 0 && guard < 400) begin
      idle(1);
      guard++;
    end
    idle(2);
    chk("drain_left", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    bit            acc;
    beat_t         b;
    int            len;
    bus.asi_in0_valid         = 1'b0;
    bus.asi_in0_data          = '0;
    bus.asi_in0_startofpacket = 1'b0;
    bus.asi_in0_endofpacket   = 1'b0;
    bus.aso_out0_ready        = 1'b1;

    // Reset state
    idle(2);
    chk("rst_out",
        {27'd0, bus.aso_out0_valid, bus.aso_out0_startofpacket,
         bus.aso_out0_endofpacket, bus.aso_out0_error,
         bus.aso_out0_data},
        64'd0);
    chk("rst_ready", 64'(bus.asi_in0_ready), 64'd0);
    rst = 1'b0;
    idle(1);
    chk("idle_ready", 64'(bus.asi_in0_ready), 64'd1);

    // Nominal symbol with latency probe
    send(TOT, 1'b1, 1'b1);
    drain();

    // Backpressure
    bp = 1'b1;
    send(TOT, 1'b1, 1'b0);
    drain();
    bp = 1'b0;

    // Truncations and length boundaries
    send(11, 1'b1, 1'b0);
    send(51, 1'b1, 1'b0);
    send(1, 1'b1, 1'b0);
    send(CP, 1'b1, 1'b0);
    send(CP + 1, 1'b1, 1'b0);
    send(TOT - 1, 1'b1, 1'b0);
    drain();

    // Overlong then clean, and one beat over
    send(90, 1'b1, 1'b0);
    send(TOT, 1'b0, 1'b0);
    send(TOT + 1, 1'b0, 1'b0);
    drain();

    // Back-to-back symbols
    for (int k = 0; k < 3; k++) send(TOT, 1'b0, 1'b0);
    drain();

    // Junk beats before a sop
    junk(5);
    send(TOT, 1'b0, 1'b0);
    drain();

    // Reset in the middle of the body
    for (int i = CP; i < 40; i++) begin
      b.d  = DW'(i);
      b.s  = (i == CP);
      b.e  = 1'b0;
      b.er = 2'b00;
      expq.push_back(b);
    end
    for (int i = 0; i < 40; i++)
      tick(1'b1, DW'(i), i == 0, 1'b0, acc);
    tick(1'b1, DW'(40), 1'b0, 1'b0, acc);
    rst = 1'b1;
    tick(1'b1, DW'(41), 1'b0, 1'b0, acc);
    chk("midrst_out",
        {27'd0, bus.aso_out0_valid, bus.aso_out0_startofpacket,
         bus.aso_out0_endofpacket, bus.aso_out0_error,
         bus.aso_out0_data},
        64'd0);
    chk("midrst_ready", 64'(bus.asi_in0_ready), 64'd0);
    chk("midrst_left", 64'(expq.size()), 64'd0);
    rst = 1'b0;
    idle(1);
    send(TOT, 1'b1, 1'b1);
    drain();

    // Randomized traffic
    mid_sop = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bp      = 1'($urandom_range(0, 1));
      gap_pct = ($urandom_range(0, 1) == 1) ? 20 : 0;
      junk($urandom_range(0, 3));
      len = ($urandom_range(0, 1) == 1)
            ? TOT : int'($urandom_range(1, 100));
      send(len, 1'b0, 1'b0);
    end
    bp = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ofdm_cp_remover.md
Name: ofdm_cp_remover

Overview:
- Receive-side counterpart of the OFDM cyclic-prefix adder.
- Accepts one Avalon-ST packet per OFDM symbol: CP_LEN prefix samples followed by N_FFT body samples, each sample packed I/Q in one beat.
- Strips the prefix and forwards the N_FFT body samples as a new packet toward the receive FFT.
- Checks symbol length and flags malformed symbols on the output error bus.

Parameters:
- DATA_W, 34, sample width (17-bit I + 17-bit Q).
- N_FFT, 64, body samples per symbol (>=2).
- CP_LEN, 16, prefix samples per symbol (>=1).

Ports:
- clk_clk  in  1  single clock.
- reset_reset  in  1  synchronous, active-high reset.
- asi_in0_data  in  DATA_W  input sample.
- asi_in0_valid  in  1  input beat valid.
- asi_in0_ready  out  1  input backpressure.
- asi_in0_startofpacket  in  1  first beat of symbol (first CP sample).
- asi_in0_endofpacket  in  1  last beat of symbol.
- aso_out0_data  out  DATA_W  body sample.
- aso_out0_valid  out  1  output beat valid.
- aso_out0_ready  in  1  downstream ready.
- aso_out0_startofpacket  out  1  first body sample.
- aso_out0_endofpacket  out  1  last forwarded sample.
- aso_out0_error  out  2  bit0 = truncated symbol; bit1 = overlong symbol. Valid only on the eop beat, 0 elsewhere.

Behaviour:
- Transfers:
  - Input transfer = asi_in0_valid & asi_in0_ready.
  - Output transfer = aso_out0_valid & aso_out0_ready.
  - Output ready latency 0; aso_out0_* held stable while valid & !ready.
- Reset:
  - State IDLE, index counter 0.
  - aso_out0_valid/sop/eop/error = 0, aso_out0_data = 0.
  - asi_in0_ready = 0 while reset_reset is high.
- Index counter: counts input beats within the symbol, 0 .. CP_LEN+N_FFT-1; width clog2(CP_LEN+N_FFT).
- States:
  - IDLE: beats without sop are dropped. A sop beat is index 0 (a CP sample), is dropped, and moves to DROP; if it also carries eop, stay in IDLE and emit nothing.
  - DROP: beats dropped until index CP_LEN-1, then go to PASS. If CP_LEN==1, the sop beat goes directly to PASS. Input eop in DROP abandons the symbol: nothing emitted, go to IDLE.
  - PASS: every beat is forwarded.
    - Index CP_LEN carries out sop=1.
    - Index CP_LEN+N_FFT-1 carries out eop=1, then go to IDLE. If the input eop is absent on that beat, error=2'b10 and go to DISCARD.
    - Input eop before the final index: forward that beat with eop=1, error=2'b01, go to IDLE.
  - DISCARD: drop beats up to and including the next input eop, then go to IDLE.
- Mid-symbol sop (any state other than IDLE) is ignored and treated as an ordinary sample; framing is count-based.
- Output stage: one register. asi_in0_ready = !reset_reset & (state!=PASS | !aso_out0_valid | aso_out0_ready). Dropping states never stall.
- Latency: input beat to output beat = 1 cycle.
- Throughput: 1 beat/clk with no gap between symbols. A new sop is accepted in IDLE on the cycle after the previous input eop.
- Reset mid-packet: the partial output packet is abandoned (no eop emitted) and the output register is cleared the next cycle.
- Data passes unmodified, bit-exact.

Test Plan (N_FFT=64, CP_LEN=16):
- Nominal symbol: 80 beats, data=index, sop@0, eop@79, out_ready=1 -> 64 beats data 16..79; sop on 16, eop on 79, error=00; first output 1 cycle after input index 16.
- Backpressure: same symbol, aso_out0_ready toggled pseudo-randomly -> asi_in0_ready low only while in PASS with stalled output; data 16..79 in order, no loss or duplication; held values stable during stalls.
- Truncated in prefix / in body:
  - eop at index 10 -> no output beats.
  - eop at index 50 -> 35 beats data 16..50; eop on 50, error=01.
- Overlong: 90-beat symbol, eop@89 -> 64 beats; eop on 79, error=10; beats 80..89 dropped; next symbol processed normally.
- Back-to-back and junk:
  - 3 consecutive 80-beat symbols with no idle cycles -> 3 clean 64-beat packets.
  - Non-sop beats before a sop are dropped.
- Reset mid-PASS at input index 40 -> outputs 0 next cycle, asi_in0_ready=0 during reset; following nominal symbol yields a clean 64-beat packet.
